// File: rtl/expr_checker.sv
// expr_checker: streaming ASCII arithmetic-expression recogniser.
// Consumes one character per clock when in_valid=1 and reports whether the
// characters accepted since the last clr form a complete valid expression.
// Grammar: expr := term (op term)* ; term := digit{1..MAX_DIGITS} | '(' expr ')'
// Optional feature macro: EXPR_SPACE_EN (ASCII space treated as whitespace).
module expr_checker #(
  parameter  int MAX_DEPTH  = 7,
  parameter  int MAX_DIGITS = 4,
  parameter  int CNT_W      = 8,
  localparam int DEPTH_W    = $clog2(MAX_DEPTH + 1),
  localparam int DIG_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [7:0]         in,
  input  logic               in_valid,
  output logic               out,
  output logic               err,
  output logic [DEPTH_W-1:0] depth,
  output logic [CNT_W-1:0]   num_cnt
);

  typedef enum logic [2:0] {
    S_START = 3'd0,
    S_OP    = 3'd1,
    S_NUM   = 3'd2,
    S_CLOSE = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  // Power-up values match the clr values so the checker is usable before the first clr.
  state_e             state_q = S_START;
  state_e             state_d;
  logic [DEPTH_W-1:0] depth_q = '0;
  logic [DEPTH_W-1:0] depth_d;
  logic [DIG_W-1:0]   dig_q   = '0;
  logic [DIG_W-1:0]   dig_d;
  logic [CNT_W-1:0]   num_q   = '0;
  logic [CNT_W-1:0]   num_d;

  logic is_digit, is_op, is_open, is_close;
  logic depth_full, depth_zero, dig_full, num_full;

  assign is_digit   = (in >= 8'h30) && (in <= 8'h39);
  assign is_op      = (in == 8'h2B) || (in == 8'h2D) || (in == 8'h2A) || (in == 8'h2F);
  assign is_open    = (in == 8'h28);
  assign is_close   = (in == 8'h29);
  assign depth_full = (depth_q == DEPTH_W'(MAX_DEPTH));
  assign depth_zero = (depth_q == '0);
  assign dig_full   = (dig_q == DIG_W'(MAX_DIGITS));
  assign num_full   = (num_q == '1);

`ifdef EXPR_SPACE_EN
  logic is_space;
  assign is_space = (in == 8'h20);
`endif

  // Next-state logic: decide the transition for the character offered this beat.
  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    dig_d   = dig_q;
    num_d   = num_q;
    if (in_valid) begin
      case (state_q)
        S_START, S_OP: begin
          if (is_digit) begin
            state_d = S_NUM;
            dig_d   = DIG_W'(1);
            // Operand count saturates; reaching all-ones is not an error.
            num_d   = num_full ? num_q : num_q + CNT_W'(1);
          end else if (is_open && !depth_full) begin
            depth_d = depth_q + DEPTH_W'(1);
`ifdef EXPR_SPACE_EN
          end else if (is_space) begin
            state_d = state_q;
`endif
          end else begin
            state_d = S_ERR;
          end
        end
        S_NUM: begin
          if (is_digit && !dig_full) begin
            dig_d = dig_q + DIG_W'(1);
          end else if (is_op) begin
            state_d = S_OP;
            dig_d   = '0;
          end else if (is_close && !depth_zero) begin
            state_d = S_CLOSE;
            depth_d = depth_q - DEPTH_W'(1);
`ifdef EXPR_SPACE_EN
          end else if (is_space) begin
            // A space ends the operand; only an operator or ')' may follow.
            state_d = S_CLOSE;
            dig_d   = '0;
`endif
          end else begin
            state_d = S_ERR;
          end
        end
        S_CLOSE: begin
          if (is_op) begin
            state_d = S_OP;
          end else if (is_close && !depth_zero) begin
            depth_d = depth_q - DEPTH_W'(1);
`ifdef EXPR_SPACE_EN
          end else if (is_space) begin
            state_d = S_CLOSE;
`endif
          end else begin
            state_d = S_ERR;
          end
        end
        S_ERR:   state_d = S_ERR;
        default: state_d = S_ERR;
      endcase
    end
  end

  // State registers: clr restarts the checker and drops any character offered with it.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_START;
      depth_q <= '0;
      dig_q   <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      dig_q   <= dig_d;
      num_q   <= num_d;
    end
  end

  assign out     = ((state_q == S_NUM) || (state_q == S_CLOSE)) && depth_zero;
  assign err     = (state_q == S_ERR);
  assign depth   = depth_q;
  assign num_cnt = num_q;

endmodule

// File: tb/tb_expr_checker.sv
// Self-checking bench for expr_checker: directed scenarios plus randomized
// character streams compared against a string-rescanning reference model.
// Compile with +define+EXPR_SPACE_EN to exercise the whitespace feature.
module tb_expr_checker;

  localparam int MAX_DEPTH  = 7;
  localparam int MAX_DIGITS = 4;
  localparam int CNT_W      = 8;
  localparam int DEPTH_W    = $clog2(MAX_DEPTH + 1);
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               clr = 1'b0;
  logic [7:0]         in_c = 8'h00;
  logic               in_valid = 1'b0;
  logic               out;
  logic               err;
  logic [DEPTH_W-1:0] depth;
  logic [CNT_W-1:0]   num_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state: every character accepted since the last clr.
  byte unsigned hist[$];
  int m_out, m_err, m_depth, m_num;

  expr_checker #(
    .MAX_DEPTH (MAX_DEPTH),
    .MAX_DIGITS(MAX_DIGITS),
    .CNT_W     (CNT_W)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .in      (in_c),
    .in_valid(in_valid),
    .out     (out),
    .err     (err),
    .depth   (depth),
    .num_cnt (num_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Re-scan the whole accepted string token by token and derive the expected outputs.
  // Scanning stops at the first illegal character, which freezes depth and operand count.
  function automatic void rescan();
    bit need_operand = 1'b1;
    int run = 0;
    int d = 0;
    int cnt = 0;
    bit bad = 1'b0;
    foreach (hist[i]) begin
      byte unsigned c = hist[i];
      if (c >= "0" && c <= "9") begin
        if (need_operand) begin
          need_operand = 1'b0;
          run = 1;
          if (cnt < CNT_MAX) cnt++;
        end else if (run > 0 && run < MAX_DIGITS) run++;
        else bad = 1'b1;
      end else if (c == "(") begin
        if (need_operand && d < MAX_DEPTH) d++;
        else bad = 1'b1;
      end else if (c == ")") begin
        if (!need_operand && d > 0) begin
          d--;
          run = 0;
        end else bad = 1'b1;
      end else if (c == "+" || c == "-" || c == "*" || c == "/") begin
        if (!need_operand) begin
          need_operand = 1'b1;
          run = 0;
        end else bad = 1'b1;
`ifdef EXPR_SPACE_EN
      end else if (c == " ") begin
        run = 0;
`endif
      end else begin
        bad = 1'b1;
      end
      if (bad) break;
    end
    m_err   = bad ? 1 : 0;
    m_out   = (!bad && !need_operand && d == 0) ? 1 : 0;
    m_depth = d;
    m_num   = cnt;
  endfunction

  // One clock beat: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic beat(input byte unsigned c, input bit v, input bit r);
    @(negedge clk);
    in_c     = c;
    in_valid = v;
    clr      = r;
    @(posedge clk);
    #1;
    if (r) hist.delete();
    else if (v) hist.push_back(c);
    rescan();
    check("out", int'(out), m_out);
    check("err", int'(err), m_err);
    check("depth", int'(depth), m_depth);
    check("num_cnt", int'(num_cnt), m_num);
    clr      = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) beat(s[i], 1'b1, 1'b0);
  endtask

  function automatic byte unsigned rand_char();
    int r = $urandom_range(0, 99);
    string ops = "+-*/";
    string junk = "a= x";
    if (r < 45) return byte'("0" + $urandom_range(0, 9));
    if (r < 65) return ops[$urandom_range(0, 3)];
    if (r < 77) return "(";
    if (r < 89) return ")";
    if (r < 94) return " ";
    return junk[$urandom_range(0, 3)];
  endfunction

  initial begin
    int exp_out1[7] = '{1, 1, 0, 1, 0, 1, 1};
    int exp_dep2[9] = '{1, 1, 1, 2, 2, 2, 2, 1, 0};
    string s;

    // Power-up state before any clr, with nothing offered.
    beat(8'h00, 1'b0, 1'b0);
    check("pwrup_out", int'(out), 0);
    check("pwrup_err", int'(err), 0);

    beat(8'h00, 1'b0, 1'b1);
    check("rst_num", int'(num_cnt), 0);
    check("rst_depth", int'(depth), 0);

    s = "12+3*45";
    for (int i = 0; i < 7; i++) begin
      beat(s[i], 1'b1, 1'b0);
      check("t1_out", int'(out), exp_out1[i]);
    end
    check("t1_num", int'(num_cnt), 3);
    check("t1_err", int'(err), 0);

    beat(8'h00, 1'b0, 1'b1);
    s = "(7-(8/9))";
    for (int i = 0; i < 9; i++) begin
      beat(s[i], 1'b1, 1'b0);
      check("t2_depth", int'(depth), exp_dep2[i]);
      check("t2_out", int'(out), (i == 8) ? 1 : 0);
    end

    beat(8'h00, 1'b0, 1'b1);
    send("1234");
    check("t3_out4", int'(out), 1);
    send("5");
    check("t3_err5", int'(err), 1);
    check("t3_out5", int'(out), 0);
    send("+1");
    check("t3_sticky", int'(err), 1);

    beat(8'h00, 1'b0, 1'b1);
    send("+");
    check("t4_lead_op", int'(err), 1);
    beat(8'h00, 1'b0, 1'b1);
    send("3)");
    check("t4_close", int'(err), 1);
    beat(8'h00, 1'b0, 1'b1);
    send("3+");
    check("t4_one_op", int'(err), 0);
    send("+");
    check("t4_two_op", int'(err), 1);
    beat(8'h00, 1'b0, 1'b1);
    send("(((((((");
    check("t4_d7_err", int'(err), 0);
    send("(");
    check("t4_d8_err", int'(err), 1);
    check("t4_d8_depth", int'(depth), 7);

    beat(8'h00, 1'b0, 1'b1);
    beat("5", 1'b1, 1'b0);
    beat("9", 1'b0, 1'b0);
    beat("+", 1'b1, 1'b0);
    check("t5_held", int'(out), 0);
    check("t5_held_err", int'(err), 0);
    beat("1", 1'b1, 1'b1);
    check("t5_clr_out", int'(out), 0);
    check("t5_clr_num", int'(num_cnt), 0);
    beat("1", 1'b1, 1'b0);
    check("t5_after", int'(out), 1);

`ifdef EXPR_SPACE_EN
    beat(8'h00, 1'b0, 1'b1);
    send("1 + 2");
    check("t6_sp_out", int'(out), 1);
    check("t6_sp_err", int'(err), 0);
    beat(8'h00, 1'b0, 1'b1);
    send("1 2");
    check("t6_sp_gap", int'(err), 1);
`else
    beat(8'h00, 1'b0, 1'b1);
    send("1 ");
    check("t6_nosp", int'(err), 1);
`endif

    // Operand counter saturation without error.
    beat(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < CNT_MAX + 4; i++) send("7+");
    send("7");
    check("sat_num", int'(num_cnt), CNT_MAX);
    check("sat_err", int'(err), 0);
    check("sat_out", int'(out), 1);

    // Randomized streams with random qualifier and occasional restarts.
    beat(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4000; i++) begin
      beat(rand_char(), ($urandom_range(0, 9) < 8), ($urandom_range(0, 24) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
